// File: rtl/digit_entry_buffer.sv
// rtl/digit_entry_buffer.sv - keypad digit FIFO that replays a sequence to the detector on ENTER
//
// Collects keypad digits into a FIFO. ENTER (with at least one digit buffered)
// produces a one-cycle start pulse, then the buffered digits are streamed
// back-to-back, one per clock, on o_digit_out.
//
// Optional build macro: AUTO_ENTER_EN - a push that fills the buffer launches
// the start/stream sequence on its own, as if ENTER had been pressed.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_asyn_rst   asynchronous reset, active-high
//   i_key_valid  i_key_code valid this cycle
//   i_key_code   0..9 digit, ENTER_CODE, CLEAR_CODE; other codes ignored
//   o_start      one-cycle pulse ahead of the digit stream
//   o_digit_out  streamed digit (0 when not streaming)
//   o_busy       high while starting/streaming; keys are discarded
//   o_overflow   sticky: a digit was dropped on a full buffer
//   o_count      digits currently buffered
module digit_entry_buffer #(
    parameter int              N          = 4,
    parameter int              DEPTH      = 8,
    parameter logic [N-1:0]    ENTER_CODE = 4'hE,
    parameter logic [N-1:0]    CLEAR_CODE = 4'hA
) (
    input  logic                         i_clk,
    input  logic                         i_asyn_rst,
    input  logic                         i_key_valid,
    input  logic [N-1:0]                 i_key_code,
    output logic                         o_start,
    output logic [N-1:0]                 o_digit_out,
    output logic                         o_busy,
    output logic                         o_overflow,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [N-1:0]  MAX_DIGIT = N'(9);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_START   = 2'd1,
        S_STREAM  = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_start;
    logic [N-1:0]    r_digit_out;
    logic            r_busy;
    logic            r_overflow;

    logic            w_is_digit;
    logic            w_full;
    logic            w_push;
    logic [AW-1:0]   w_wr_ptr_nxt;
    logic [AW-1:0]   w_rd_ptr_nxt;

    assign w_is_digit   = (i_key_code <= MAX_DIGIT);
    assign w_full       = (r_count == FULL_CNT);
    assign w_push       = (r_state == S_COLLECT) && i_key_valid && w_is_digit && !w_full;
    // Explicit wrap so non-power-of-two depths stay modulo DEPTH.
    assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + AW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + AW'(1);

    // Storage array carries no reset; only the pointers define its contents.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_key_code;
        end
    end

    always_ff @(posedge i_clk or posedge i_asyn_rst) begin
        if (i_asyn_rst) begin
            r_state     <= S_COLLECT;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_start     <= 1'b0;
            r_digit_out <= '0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    r_start     <= 1'b0;
                    r_digit_out <= '0;
                    r_busy      <= 1'b0;
                    if (i_key_valid) begin
                        if (w_is_digit) begin
                            if (!w_full) begin
                                r_wr_ptr <= w_wr_ptr_nxt;
                                r_count  <= r_count + CW'(1);
`ifdef AUTO_ENTER_EN
                                if (r_count == FULL_CNT - CW'(1)) begin
                                    r_state <= S_START;
                                end
`endif
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end else if (i_key_code == CLEAR_CODE) begin
                            r_wr_ptr   <= '0;
                            r_rd_ptr   <= '0;
                            r_count    <= '0;
                            r_overflow <= 1'b0;
                        end else if (i_key_code == ENTER_CODE && r_count != '0) begin
                            r_state <= S_START;
                        end
                    end
                end
                S_START: begin
                    r_start     <= 1'b1;
                    r_digit_out <= '0;
                    r_busy      <= 1'b1;
                    r_state     <= S_STREAM;
                end
                S_STREAM: begin
                    r_start     <= 1'b0;
                    r_busy      <= 1'b1;
                    r_digit_out <= r_mem[r_rd_ptr];
                    r_rd_ptr    <= w_rd_ptr_nxt;
                    r_count     <= r_count - CW'(1);
                    // Busy and digit_out drop one cycle later, in COLLECT, so the
                    // last digit still gets its full cycle with busy high.
                    if (r_count == CW'(1)) begin
                        r_state <= S_COLLECT;
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

    assign o_start     = r_start;
    assign o_digit_out = r_digit_out;
    assign o_busy      = r_busy;
    assign o_overflow  = r_overflow;
    assign o_count     = r_count;

endmodule
